// File: rtl/ingress_voq_port.sv
// Ingress port of the crossbar: four per-egress descriptor VOQs plus a grant-driven
// transmit FSM that streams the selected packet's beat indices toward the crossbar.
module ingress_voq_port #(
    parameter int DESC_DEPTH = 8,
    parameter int LEN_W      = 6,
    parameter int ID_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_valid,
    input  logic [1:0]       enq_voq,
    input  logic [LEN_W-1:0] enq_len,
    input  logic [ID_W-1:0]  enq_pkt_id,
    output logic             enq_ready,
    output logic [3:0]       voq_empty,
    output logic             is_busy,
    output logic [1:0]       busy_voq_num,
    input  logic             sel_en,
    input  logic [1:0]       sel,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [1:0]       tx_egress,
    output logic [ID_W-1:0]  tx_pkt_id,
    output logic [LEN_W-1:0] tx_beat,
    output logic             tx_last,
    output logic [7:0]       grant_miss_cnt,
    output logic             sel_mismatch
);

    localparam int AW = $clog2(DESC_DEPTH);
    localparam int DW = ID_W + LEN_W;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t           state_reg;
    logic             sel_en_q_reg;
    logic             grant;
    logic             pop_req;
    logic [3:0]       empty_vec;
    logic [3:0]       full_vec;
    logic [3:0]       push_vec;
    logic [3:0]       pop_vec;
    logic [DW-1:0]    head_desc [4];
    logic [DW-1:0]    sel_head;
    logic [LEN_W-1:0] sel_head_last;

    logic             tx_valid_reg;
    logic [1:0]       tx_egress_reg;
    logic [ID_W-1:0]  tx_pkt_id_reg;
    logic [LEN_W-1:0] tx_beat_reg;
    logic [LEN_W-1:0] tx_beat_inc;
    logic             tx_last_reg;
    logic [LEN_W-1:0] last_idx_reg;
    logic             is_busy_reg;
    logic [1:0]       busy_voq_reg;
    logic [7:0]       miss_cnt_reg;
    logic             mismatch_reg;

    // A grant is only the rising edge of sel_en; a held level is ignored.
    assign grant   = sel_en & ~sel_en_q_reg;
    assign pop_req = (state_reg == IDLE) & grant & ~empty_vec[sel];

    assign enq_ready = ~full_vec[enq_voq];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_voq
            logic [DW-1:0] mem [DESC_DEPTH];
            logic [AW:0]   wr_ptr_reg;
            logic [AW:0]   rd_ptr_reg;
            logic [AW:0]   wr_ptr_next;
            logic [AW:0]   rd_ptr_next;
            logic          empty_reg;
            logic          full_reg;

            assign push_vec[gi] = enq_valid & ~full_reg & (enq_voq == 2'(gi));
            assign pop_vec[gi]  = pop_req & (sel == 2'(gi));

            assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_vec[gi]};
            assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_vec[gi]};

            always_ff @(posedge clk) begin
                if (push_vec[gi]) begin
                    mem[wr_ptr_reg[AW-1:0]] <= {enq_pkt_id, enq_len};
                end
            end

            // Flags come from the next pointers so push and pop in one cycle both count.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    empty_reg  <= 1'b1;
                    full_reg   <= 1'b0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    empty_reg  <= (wr_ptr_next == rd_ptr_next);
                    full_reg   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
                end
            end

            assign empty_vec[gi] = empty_reg;
            assign full_vec[gi]  = full_reg;
            assign head_desc[gi] = mem[rd_ptr_reg[AW-1:0]];
        end
    endgenerate

    assign sel_head = head_desc[sel];
    // len==0 wraps to all-ones here, which is exactly the last index of a 2**LEN_W packet.
    assign sel_head_last = sel_head[LEN_W-1:0] - {{(LEN_W-1){1'b0}}, 1'b1};
    assign tx_beat_inc   = tx_beat_reg + {{(LEN_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sel_en_q_reg  <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_egress_reg <= '0;
            tx_pkt_id_reg <= '0;
            tx_beat_reg   <= '0;
            tx_last_reg   <= 1'b0;
            last_idx_reg  <= '0;
            is_busy_reg   <= 1'b0;
            busy_voq_reg  <= '0;
            miss_cnt_reg  <= '0;
            mismatch_reg  <= 1'b0;
        end else begin
            sel_en_q_reg <= sel_en;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        if (!empty_vec[sel]) begin
                            state_reg     <= XFER;
                            tx_valid_reg  <= 1'b1;
                            is_busy_reg   <= 1'b1;
                            busy_voq_reg  <= sel;
                            tx_egress_reg <= sel;
                            tx_pkt_id_reg <= sel_head[DW-1:LEN_W];
                            last_idx_reg  <= sel_head_last;
                            tx_beat_reg   <= '0;
                            tx_last_reg   <= (sel_head_last == '0);
                        end else if (miss_cnt_reg != 8'hFF) begin
                            miss_cnt_reg <= miss_cnt_reg + 8'd1;
                        end
                    end
                end
                XFER: begin
                    if (grant && (sel != busy_voq_reg)) begin
                        mismatch_reg <= 1'b1;
                    end
                    if (tx_ready) begin
                        if (tx_last_reg) begin
                            state_reg     <= IDLE;
                            tx_valid_reg  <= 1'b0;
                            is_busy_reg   <= 1'b0;
                            tx_egress_reg <= '0;
                            tx_pkt_id_reg <= '0;
                            tx_beat_reg   <= '0;
                            tx_last_reg   <= 1'b0;
                        end else begin
                            tx_beat_reg <= tx_beat_inc;
                            tx_last_reg <= (tx_beat_inc == last_idx_reg);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign voq_empty      = empty_vec;
    assign is_busy        = is_busy_reg;
    assign busy_voq_num   = busy_voq_reg;
    assign tx_valid       = tx_valid_reg;
    assign tx_egress      = tx_egress_reg;
    assign tx_pkt_id      = tx_pkt_id_reg;
    assign tx_beat        = tx_beat_reg;
    assign tx_last        = tx_last_reg;
    assign grant_miss_cnt = miss_cnt_reg;
    assign sel_mismatch   = mismatch_reg;

endmodule

// File: tb/tb_ingress_voq_port.sv
// Directed bench for ingress_voq_port: a per-cycle vector table for a basic packet
// flow, then hand-written sequences for hold, miss saturation, full VOQ, mismatch and reset.
module tb_ingress_voq_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       enq_valid;
    logic [1:0] enq_voq;
    logic [5:0] enq_len;
    logic [7:0] enq_pkt_id;
    logic       enq_ready;
    logic [3:0] voq_empty;
    logic       is_busy;
    logic [1:0] busy_voq_num;
    logic       sel_en;
    logic [1:0] sel;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] tx_egress;
    logic [7:0] tx_pkt_id;
    logic [5:0] tx_beat;
    logic       tx_last;
    logic [7:0] grant_miss_cnt;
    logic       sel_mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    ingress_voq_port #(.DESC_DEPTH(8), .LEN_W(6), .ID_W(8)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_voq(enq_voq), .enq_len(enq_len), .enq_pkt_id(enq_pkt_id),
        .enq_ready(enq_ready), .voq_empty(voq_empty), .is_busy(is_busy),
        .busy_voq_num(busy_voq_num), .sel_en(sel_en), .sel(sel),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_egress(tx_egress),
        .tx_pkt_id(tx_pkt_id), .tx_beat(tx_beat), .tx_last(tx_last),
        .grant_miss_cnt(grant_miss_cnt), .sel_mismatch(sel_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       enq_valid;
        logic [1:0] enq_voq;
        logic [5:0] enq_len;
        logic [7:0] enq_id;
        logic       sel_en;
        logic [1:0] sel;
        logic       tx_ready;
        logic       exp_valid;
        logic [5:0] exp_beat;
        logic       exp_last;
        logic       exp_busy;
        logic [1:0] exp_bvn;
        logic [3:0] exp_empty;
        logic [1:0] exp_eg;
        logic [7:0] exp_id;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] v, input logic [5:0] l, input logic [7:0] id);
        enq_valid  = 1'b1;
        enq_voq    = v;
        enq_len    = l;
        enq_pkt_id = id;
        step();
        enq_valid  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_voq_empty"}, 32'(voq_empty), 32'hF);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_is_busy"}, 32'(is_busy), 32'd0);
        chk({tag, "_busy_voq"}, 32'(busy_voq_num), 32'd0);
        chk({tag, "_tx_egress"}, 32'(tx_egress), 32'd0);
        chk({tag, "_tx_pkt_id"}, 32'(tx_pkt_id), 32'd0);
        chk({tag, "_tx_beat"}, 32'(tx_beat), 32'd0);
        chk({tag, "_tx_last"}, 32'(tx_last), 32'd0);
        chk({tag, "_miss_cnt"}, 32'(grant_miss_cnt), 32'd0);
        chk({tag, "_mismatch"}, 32'(sel_mismatch), 32'd0);
    endtask

    initial begin
        int  seen;
        int  beats;
        bit  done;
        logic [7:0] first_id;

        // {enq_valid,voq,len,id, sel_en,sel,tx_ready, valid,beat,last,busy,bvn,empty,egress,id}
        vecs[0] = '{1'b1, 2'd2, 6'd3, 8'h11, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 4'b1011, 2'd0, 8'h00};
        vecs[1] = '{1'b0, 2'd0, 6'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1, 2'd2, 4'b1111, 2'd2, 8'h11};
        vecs[2] = '{1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 2'd2, 4'b1111, 2'd2, 8'h11};
        vecs[3] = '{1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 6'd1, 1'b0, 1'b1, 2'd2, 4'b1111, 2'd2, 8'h11};
        vecs[4] = '{1'b1, 2'd1, 6'd1, 8'h22, 1'b0, 2'd0, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1, 2'd2, 4'b1101, 2'd2, 8'h11};
        vecs[5] = '{1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 4'b1101, 2'd0, 8'h00};
        vecs[6] = '{1'b0, 2'd0, 6'd0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 2'd1, 4'b1111, 2'd1, 8'h22};
        vecs[7] = '{1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 4'b1111, 2'd0, 8'h00};
        vecs[8] = '{1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 4'b1111, 2'd0, 8'h00};

        enq_valid = 1'b0; enq_voq = '0; enq_len = '0; enq_pkt_id = '0;
        sel_en = 1'b0; sel = '0; tx_ready = 1'b1;
        reset = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        chk("reset_enq_ready", 32'(enq_ready), 32'd1);
        reset = 1'b0;
        step();

        // Basic packet flow driven from the vector table.
        for (int i = 0; i < 9; i++) begin
            enq_valid  = vecs[i].enq_valid;
            enq_voq    = vecs[i].enq_voq;
            enq_len    = vecs[i].enq_len;
            enq_pkt_id = vecs[i].enq_id;
            sel_en     = vecs[i].sel_en;
            sel        = vecs[i].sel;
            tx_ready   = vecs[i].tx_ready;
            step();
            $display("vec %0d: valid=%0d beat=%0d last=%0d busy=%0d empty=%b id=%0h",
                     i, tx_valid, tx_beat, tx_last, is_busy, voq_empty, tx_pkt_id);
            chk("vec_tx_valid", 32'(tx_valid), 32'(vecs[i].exp_valid));
            chk("vec_is_busy", 32'(is_busy), 32'(vecs[i].exp_busy));
            chk("vec_voq_empty", 32'(voq_empty), 32'(vecs[i].exp_empty));
            if (vecs[i].exp_valid) begin
                chk("vec_tx_beat", 32'(tx_beat), 32'(vecs[i].exp_beat));
                chk("vec_tx_last", 32'(tx_last), 32'(vecs[i].exp_last));
                chk("vec_tx_egress", 32'(tx_egress), 32'(vecs[i].exp_eg));
                chk("vec_tx_pkt_id", 32'(tx_pkt_id), 32'(vecs[i].exp_id));
            end
            if (vecs[i].exp_busy) begin
                chk("vec_busy_voq", 32'(busy_voq_num), 32'(vecs[i].exp_bvn));
            end
        end
        enq_valid = 1'b0; sel_en = 1'b0; tx_ready = 1'b1;

        // Held sel_en sends exactly one packet; a fresh edge sends the next.
        enq(2'd2, 6'd1, 8'h31);
        enq(2'd2, 6'd1, 8'h32);
        sel = 2'd2;
        sel_en = 1'b1;
        seen = 0;
        first_id = 8'h00;
        for (int c = 0; c < 10; c++) begin
            step();
            if (tx_valid) begin
                if (seen == 0) first_id = tx_pkt_id;
                seen++;
            end
        end
        $display("hold: packets=%0d first_id=%0h", seen, first_id);
        chk("hold_pkt_count", 32'(seen), 32'd1);
        chk("hold_first_id", 32'(first_id), 32'h31);
        chk("hold_voq2_nonempty", 32'(voq_empty[2]), 32'd0);
        sel_en = 1'b0;
        step();
        sel_en = 1'b1;
        step();
        chk("regrant_valid", 32'(tx_valid), 32'd1);
        chk("regrant_id", 32'(tx_pkt_id), 32'h32);
        sel_en = 1'b0;
        step();
        chk("regrant_done", 32'(tx_valid), 32'd0);
        chk("regrant_empty", 32'(voq_empty), 32'hF);

        // Grants to an empty VOQ count as misses and saturate.
        sel = 2'd1;
        sel_en = 1'b1;
        step();
        $display("miss: valid=%0d cnt=%0d", tx_valid, grant_miss_cnt);
        chk("miss_no_valid", 32'(tx_valid), 32'd0);
        chk("miss_cnt_1", 32'(grant_miss_cnt), 32'd1);
        sel_en = 1'b0;
        step();
        for (int m = 0; m < 299; m++) begin
            sel_en = 1'b1;
            step();
            sel_en = 1'b0;
            step();
        end
        $display("miss: cnt after 300 = %0d", grant_miss_cnt);
        chk("miss_cnt_sat", 32'(grant_miss_cnt), 32'd255);
        chk("miss_never_valid", 32'(tx_valid), 32'd0);

        // Fill VOQ0, overflow is dropped, other VOQs still accept.
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1; enq_voq = 2'd0; enq_len = 6'd1; enq_pkt_id = 8'(8'h40 + i);
            #1;
            chk("fill_ready", 32'(enq_ready), 32'd1);
            step();
        end
        enq_pkt_id = 8'h48;
        #1;
        $display("full: enq_ready voq0=%0d", enq_ready);
        chk("full_ready_low", 32'(enq_ready), 32'd0);
        step();
        enq_voq = 2'd3; enq_len = 6'd4; enq_pkt_id = 8'h50;
        #1;
        chk("other_voq_ready", 32'(enq_ready), 32'd1);
        step();
        enq_valid = 1'b0;
        chk("full_empty_flags", 32'(voq_empty), 32'b0110);
        sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            sel_en = 1'b1;
            step();
            $display("drain %0d: valid=%0d id=%0h", i, tx_valid, tx_pkt_id);
            chk("drain_valid", 32'(tx_valid), 32'd1);
            chk("drain_id", 32'(tx_pkt_id), 32'(8'h40 + i));
            sel_en = 1'b0;
            step();
        end
        chk("drain_voq0_empty", 32'(voq_empty[0]), 32'd1);
        sel_en = 1'b1;
        step();
        chk("overflow_dropped", 32'(tx_valid), 32'd0);
        sel_en = 1'b0;
        step();

        // Re-grants during a transfer never pop; a different sel flags mismatch.
        enq(2'd1, 6'd2, 8'h60);
        sel = 2'd3; sel_en = 1'b1; tx_ready = 1'b0;
        step();
        chk("x3_valid", 32'(tx_valid), 32'd1);
        chk("x3_egress", 32'(tx_egress), 32'd3);
        chk("x3_id", 32'(tx_pkt_id), 32'h50);
        chk("x3_busy_voq", 32'(busy_voq_num), 32'd3);
        sel_en = 1'b0; tx_ready = 1'b1;
        step();
        chk("x3_beat1", 32'(tx_beat), 32'd1);
        tx_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sel_en = (c % 2 == 0);
            sel    = (c == 0) ? 2'd1 : 2'd3;
            step();
            $display("stall %0d: valid=%0d beat=%0d id=%0h mismatch=%0d empty=%b",
                     c, tx_valid, tx_beat, tx_pkt_id, sel_mismatch, voq_empty);
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_beat", 32'(tx_beat), 32'd1);
            chk("stall_last", 32'(tx_last), 32'd0);
            chk("stall_id", 32'(tx_pkt_id), 32'h50);
            chk("stall_egress", 32'(tx_egress), 32'd3);
            chk("stall_mismatch", 32'(sel_mismatch), 32'd1);
        end
        chk("stall_no_pop", 32'(voq_empty), 32'b1101);

        // Asynchronous reset mid-packet drops everything.
        sel_en = 1'b0;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        step();
        reset = 1'b0;
        tx_ready = 1'b1;
        step();

        // len==0 is a full 64-beat packet.
        enq(2'd0, 6'd0, 8'h70);
        sel = 2'd0; sel_en = 1'b1;
        step();
        sel_en = 1'b0;
        chk("long_id", 32'(tx_pkt_id), 32'h70);
        beats = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (tx_valid) begin
                chk("long_beat_idx", 32'(tx_beat), 32'(beats));
                if (tx_last) done = 1'b1;
                beats++;
            end
            step();
        end
        $display("long: beats=%0d done=%0d", beats, done);
        chk("long_done", 32'(done), 32'd1);
        chk("long_beats", 32'(beats), 32'd64);
        chk("long_end_valid", 32'(tx_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
